// File: rtl/red_pitaya_clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock/pulse divider.
// Optional feature macro: CLK_DIV_PHASE_EN (adds a per-channel restart phase).
package red_pitaya_clk_div_pkg;

  // Default counter/period/high-time width in bits.
  localparam int CW_DEF    = 28;
  // Period every channel runs with after reset (cycles); high time is half of it.
  localparam int RST_P_DEF = 100;
  // Smallest period that can be applied; shorter requests are raised to this.
  localparam int P_MIN     = 2;

  // Configuration record layout at the default width: period, high time, phase.
  typedef struct packed {
    logic [CW_DEF-1:0] period;
    logic [CW_DEF-1:0] high;
    logic [CW_DEF-1:0] phase;
  } cfg_t;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/red_pitaya_clk_div_multi_if.sv
// Control/status bundle of the multi-channel divider.
// Optional feature macro: CLK_DIV_PHASE_EN (adds cfg_phase_i).
interface red_pitaya_clk_div_multi_if
  import red_pitaya_clk_div_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = CW_DEF
);

  localparam int CHW = ch_w(NCH);

  logic [NCH-1:0] en_i;
  logic           sync_i;
  logic           cfg_we_i;
  logic [CHW-1:0] cfg_ch_i;
  logic [CW-1:0]  cfg_period_i;
  logic [CW-1:0]  cfg_high_i;
`ifdef CLK_DIV_PHASE_EN
  logic [CW-1:0]  cfg_phase_i;
`endif
  logic [NCH-1:0] clk_o;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] pend_o;

`ifdef CLK_DIV_PHASE_EN
  modport master (
    output en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i, cfg_high_i, cfg_phase_i,
    input  clk_o, tick_o, pend_o
  );
  modport slave (
    input  en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i, cfg_high_i, cfg_phase_i,
    output clk_o, tick_o, pend_o
  );
`else
  modport master (
    output en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i, cfg_high_i,
    input  clk_o, tick_o, pend_o
  );
  modport slave (
    input  en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i, cfg_high_i,
    output clk_o, tick_o, pend_o
  );
`endif

endinterface

// File: rtl/red_pitaya_clk_div_ch.sv
// One divider channel: shadow config, active config, counter and registered outputs.
// New configuration lands in the shadow and is applied only at a period boundary
// (wrap), on a restart (sync / enable rising) or while the channel is disabled,
// so the output never shows a truncated or stretched period.
// Optional feature macro: CLK_DIV_PHASE_EN (restart loads a programmable phase).
module red_pitaya_clk_div_ch
  import red_pitaya_clk_div_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int RST_P = RST_P_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          sync_i,
  input  logic          we_i,
  input  logic [CW-1:0] period_i,
  input  logic [CW-1:0] high_i,
`ifdef CLK_DIV_PHASE_EN
  input  logic [CW-1:0] phase_i,
`endif
  output logic          clk_o,
  output logic          tick_o,
  output logic          pend_o
);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] ZERO    = CW'(0);
  localparam logic [CW-1:0] P_FLOOR = CW'(P_MIN);
  localparam logic [CW-1:0] P_RST   = CW'(RST_P);
  localparam logic [CW-1:0] H_RST   = CW'(RST_P / 2);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] act_p_r;
  logic [CW-1:0] act_h_r;
  logic [CW-1:0] sh_p_r;
  logic [CW-1:0] sh_h_r;
  logic          pend_r;
  logic          en_d_r;
  logic          clk_r;
  logic          tick_r;
`ifdef CLK_DIV_PHASE_EN
  logic [CW-1:0] act_ph_r;
  logic [CW-1:0] sh_ph_r;
  logic [CW-1:0] ph_nx_s;
`endif

  logic          rise_s;
  logic          restart_s;
  logic          wrap_s;
  logic          apply_s;
  logic [CW-1:0] p_nx_s;
  logic [CW-1:0] h_nx_s;
  logic [CW-1:0] restart_val_s;
  logic [CW-1:0] cnt_nx_s;
  logic          clk_nx_s;
  logic          tick_nx_s;

  // Next counter, next active config and next output values for this edge.
  always_comb begin
    rise_s    = en_i & ~en_d_r;
    restart_s = en_i & (sync_i | rise_s);
    wrap_s    = (cnt_r == (act_p_r - ONE));

    if (!en_i) begin
      apply_s = pend_r;
    end else if (restart_s || wrap_s) begin
      apply_s = pend_r;
    end else begin
      apply_s = 1'b0;
    end

    if (apply_s) begin
      p_nx_s = (sh_p_r < P_FLOOR) ? P_FLOOR : sh_p_r;
      h_nx_s = sh_h_r;
    end else begin
      p_nx_s = act_p_r;
      h_nx_s = act_h_r;
    end

`ifdef CLK_DIV_PHASE_EN
    ph_nx_s       = apply_s ? sh_ph_r : act_ph_r;
    restart_val_s = (ph_nx_s < p_nx_s) ? ph_nx_s : ZERO;
`else
    restart_val_s = ZERO;
`endif

    if (!en_i) begin
      cnt_nx_s = ZERO;
    end else if (restart_s) begin
      cnt_nx_s = restart_val_s;
    end else if (wrap_s) begin
      cnt_nx_s = ZERO;
    end else begin
      cnt_nx_s = cnt_r + ONE;
    end

    clk_nx_s  = en_i & (cnt_nx_s < h_nx_s);
    tick_nx_s = en_i & (cnt_nx_s == (p_nx_s - ONE));
  end

  // Counter, config registers and outputs all advance on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r    <= ZERO;
      act_p_r  <= P_RST;
      act_h_r  <= H_RST;
      sh_p_r   <= P_RST;
      sh_h_r   <= H_RST;
      pend_r   <= 1'b0;
      en_d_r   <= 1'b0;
      clk_r    <= 1'b0;
      tick_r   <= 1'b0;
`ifdef CLK_DIV_PHASE_EN
      act_ph_r <= ZERO;
      sh_ph_r  <= ZERO;
`endif
    end else begin
      cnt_r    <= cnt_nx_s;
      act_p_r  <= p_nx_s;
      act_h_r  <= h_nx_s;
      en_d_r   <= en_i;
      clk_r    <= clk_nx_s;
      tick_r   <= tick_nx_s;
`ifdef CLK_DIV_PHASE_EN
      act_ph_r <= ph_nx_s;
`endif
      // A write always leaves a pending entry, even on the edge that applies
      // the previous one: it waits for the next boundary.
      if (we_i) begin
        sh_p_r  <= period_i;
        sh_h_r  <= high_i;
`ifdef CLK_DIV_PHASE_EN
        sh_ph_r <= phase_i;
`endif
        pend_r  <= 1'b1;
      end else if (apply_s) begin
        pend_r  <= 1'b0;
      end else begin
        pend_r  <= pend_r;
      end
    end
  end

  assign clk_o  = clk_r;
  assign tick_o = tick_r;
  assign pend_o = pend_r;

endmodule

// File: rtl/red_pitaya_clk_div_multi.sv
// N-channel programmable clock/pulse divider: write decode, per-channel
// instances and common sync fan-out.
// Optional feature macro: CLK_DIV_PHASE_EN (per-channel restart phase).
module red_pitaya_clk_div_multi
  import red_pitaya_clk_div_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CW    = CW_DEF,
  parameter int RST_P = RST_P_DEF
) (
  input logic                       clk_i,
  input logic                       rst_i,
  red_pitaya_clk_div_multi_if.slave bus
);

  localparam int CHW = ch_w(NCH);

  logic [NCH-1:0] we_s;
  logic [NCH-1:0] clk_s;
  logic [NCH-1:0] tick_s;
  logic [NCH-1:0] pend_s;

  // Address decode; channel numbers at or above NCH match nothing.
  always_comb begin
    we_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.cfg_we_i && (bus.cfg_ch_i == CHW'(i))) begin
        we_s[i] = 1'b1;
      end else begin
        we_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    red_pitaya_clk_div_ch #(
      .CW    (CW),
      .RST_P (RST_P)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (bus.en_i[g]),
      .sync_i   (bus.sync_i),
      .we_i     (we_s[g]),
      .period_i (bus.cfg_period_i),
      .high_i   (bus.cfg_high_i),
`ifdef CLK_DIV_PHASE_EN
      .phase_i  (bus.cfg_phase_i),
`endif
      .clk_o    (clk_s[g]),
      .tick_o   (tick_s[g]),
      .pend_o   (pend_s[g])
    );
  end

  assign bus.clk_o  = clk_s;
  assign bus.tick_o = tick_s;
  assign bus.pend_o = pend_s;

endmodule
